// File: rtl/dmem_resp_pkg.sv
// Shared types, derived constants and the critical-word-first wrap helper
// for the burst responder.
package dmem_resp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        WAIT,
        RBURST,
        WACK
    } state_t;

    localparam int DEF_BURST_LEN = 4;
    localparam int DEF_LATENCY   = 6;

    function automatic int beat_w(input int burst_len);
        return $clog2(burst_len);
    endfunction

    function automatic int lat_w(input int latency);
        return $clog2(latency) + 1;
    endfunction

    localparam int BEAT_W = beat_w(DEF_BURST_LEN);
    localparam int LAT_W  = lat_w(DEF_LATENCY);

    // Beat k lands at base + ((crit + k) mod burst_len); burst_len is a power of two.
    function automatic int unsigned wrap_idx(input int unsigned base, input int unsigned crit,
                                             input int unsigned k, input int unsigned burst_len);
        return base + ((crit + k) & (burst_len - 1));
    endfunction

endpackage

// File: rtl/dmem_sp_array.sv
// Single-port backing store: synchronous read (read-first), one-cycle latency, no reset.
module dmem_sp_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_burst_responder.sv
// Backing-memory responder for cache line fills / write-backs with programmable latency.
// Optional DMEM_RESP_ERR_EN adds rsp_err for addresses beyond the backing-store depth.
module dmem_burst_responder
    import dmem_resp_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 12,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy
`ifdef DMEM_RESP_ERR_EN
    ,
    output logic              rsp_err
`endif
);

    localparam int AW = DEPTH_LOG2;
    localparam int BW = beat_w(BURST_LEN);
    localparam int CW = lat_w(LATENCY);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    state_t         state, state_nxt;
    logic [AW-1:0]  base_q;
    logic [BW-1:0]  crit_q;
    logic           we_q;
    logic [BW-1:0]  beat_q;
    logic [CW-1:0]  cnt_q;
    logic [AW-1:0]  req_widx;
    logic           accept, wr_fire, kill;
    logic [BW-1:0]  ram_beat;
    logic [AW-1:0]  ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    assign req_widx = req_addr[AW+1:2];
    assign accept   = req_valid & req_ready;
    assign wr_fire  = wr_valid & wr_ready;

`ifdef DMEM_RESP_ERR_EN
    logic err_q;
    logic unused_addr;
    assign unused_addr = ^req_addr[1:0];

    always_ff @(posedge clk) begin
        if (accept) err_q <= |req_addr[31:AW+2];
    end

    assign kill    = err_q;
    assign rsp_err = rsp_valid & err_q;
`else
    logic unused_addr;
    assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
    assign kill        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            beat_q <= '0;
            cnt_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                base_q <= {req_widx[AW-1:BW], BW'(0)};
                crit_q <= req_widx[BW-1:0];
                we_q   <= req_we;
                cnt_q  <= CW'(LATENCY);
                beat_q <= '0;
            end else if (state == WDATA) begin
                if (wr_fire) begin
                    beat_q <= beat_q + BW'(1);
                    if (beat_q == LAST_BEAT) cnt_q <= CW'(LATENCY);
                end
            end else if (state == WAIT) begin
                cnt_q <= cnt_q - CW'(1);
            end else if (state == RBURST) begin
                beat_q <= beat_q + BW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        wr_ready  = 1'b0;
        rsp_valid = 1'b0;
        rsp_last  = 1'b0;
        rsp_data  = '0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_we ? WDATA : WAIT;
            end
            WDATA: begin
                wr_ready = 1'b1;
                if (wr_valid && beat_q == LAST_BEAT) state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt_q == CW'(1)) state_nxt = we_q ? WACK : RBURST;
            end
            RBURST: begin
                rsp_valid = 1'b1;
                rsp_last  = (beat_q == LAST_BEAT);
                rsp_data  = kill ? '0 : ram_rdata;
                if (beat_q == LAST_BEAT) state_nxt = IDLE;
            end
            WACK: begin
                rsp_valid = 1'b1;
                rsp_last  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs are forced quiet for the whole reset cycle, even mid-burst.
        if (rst) begin
            req_ready = 1'b0;
            wr_ready  = 1'b0;
            rsp_valid = 1'b0;
            rsp_last  = 1'b0;
            rsp_data  = '0;
            busy      = 1'b0;
        end
    end

    // Reads are issued one beat ahead: beat 0 during WAIT, beat k+1 during RBURST beat k.
    assign ram_beat = (state == RBURST) ? beat_q + BW'(1) : beat_q;
    assign ram_addr = AW'(wrap_idx(32'(base_q), 32'(crit_q), 32'(ram_beat), 32'(BURST_LEN)));

    dmem_sp_array #(
        .DATA_W (DATA_W),
        .ADDR_W (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire & ~kill),
        .addr  (ram_addr),
        .wdata (wr_data),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_burst_responder.sv
// Directed + random bench for dmem_burst_responder against a word-array reference model.
module tb_dmem_burst_responder;

    localparam int DW  = 32;
    localparam int DL  = 12;
    localparam int BL  = 4;
    localparam int LAT = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [31:0]   req_addr = '0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          req_ready, wr_ready, rsp_valid, rsp_last, busy;
    logic [DW-1:0] rsp_data;
`ifdef DMEM_RESP_ERR_EN
    logic          rsp_err;
`endif

    int vectors = 0;
    int errs    = 0;
    logic [31:0] mdl [int];
    logic [31:0] rd_beats [BL];

    always #5 clk = ~clk;

    dmem_burst_responder #(
        .DATA_W (DW), .DEPTH_LOG2 (DL), .BURST_LEN (BL), .LATENCY (LAT)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .busy      (busy)
`ifdef DMEM_RESP_ERR_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Word targeted by beat k: line base plus critical-word-first wrap.
    function automatic int unsigned line_word(input logic [31:0] a, input int k);
        int unsigned idx;
        idx = (a >> 2) % (1 << DL);
        return idx - (idx % BL) + ((idx % BL) + k) % BL;
    endfunction

    function automatic bit err_of(input logic [31:0] a);
`ifdef DMEM_RESP_ERR_EN
        return (a >> (DL + 2)) != 0;
`else
        return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("idle_wait", req_ready, 1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [BL-1:0][31:0] d, input int gap);
        int  k, n;
        bit  gapped;
        wait_idle();
        req_valid = 1'b1; req_we = 1'b1; req_addr = a;
        step();
        req_valid = 1'b0; req_we = 1'b0;
        k = 0; n = 0; gapped = 1'b0;
        while (k < BL && n < 40) begin
            chk("wr_ready", wr_ready, 1);
            if (k == gap && !gapped) begin
                wr_valid = 1'b0;
                gapped   = 1'b1;
            end else begin
                wr_valid = 1'b1;
                wr_data  = d[k];
                k++;
            end
            step();
            n++;
        end
        wr_valid = 1'b0; wr_data = '0;
        for (int i = 0; i < LAT; i++) begin
            chk("wr_wait_valid", rsp_valid, 0);
            chk("wr_wait_busy", busy, 1);
            step();
        end
        chk("wack_valid", rsp_valid, 1);
        chk("wack_last", rsp_last, 1);
        chk("wack_data", rsp_data, 0);
`ifdef DMEM_RESP_ERR_EN
        chk("wack_err", rsp_err, err_of(a));
`endif
        if (!err_of(a))
            for (int j = 0; j < BL; j++) mdl[line_word(a, j)] = d[j];
        step();
        chk("wack_done", rsp_valid, 0);
    endtask

    task automatic do_read(input logic [31:0] a, input bit hold);
        logic [31:0] exp;
        wait_idle();
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        step();
        if (!hold) req_valid = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            chk("rd_wait_valid", rsp_valid, 0);
            chk("rd_wait_busy", busy, 1);
            chk("rd_wait_ready", req_ready, 0);
            step();
        end
        for (int k = 0; k < BL; k++) begin
            exp = err_of(a) ? 32'h0 : mdl[line_word(a, k)];
            chk("rd_valid", rsp_valid, 1);
            chk("rd_data", rsp_data, exp);
            chk("rd_last", rsp_last, (k == BL - 1));
            chk("rd_busy", busy, 1);
            if (hold) chk("rd_hold_ready", req_ready, 0);
`ifdef DMEM_RESP_ERR_EN
            chk("rd_err", rsp_err, err_of(a));
`endif
            rd_beats[k] = rsp_data;
            step();
        end
    endtask

    initial begin
        logic [BL-1:0][31:0] d;
        logic [31:0] a;

        // Reset state
        step(); step();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_last", rsp_last, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        step();
        chk("idle_req_ready", req_ready, 1);

        // Preload lines 0..15 so random reads always hit known words.
        for (int l = 0; l < 16; l++) begin
            for (int j = 0; j < BL; j++) d[j] = $urandom;
            do_write(32'(l * 16), d, $urandom_range(0, 4) - 1);
        end

        // Aligned and critical-word-first line fills.
        d = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        do_write(32'h400, d, -1);
        do_read(32'h400, 1'b0);
        chk("aligned_b0", rd_beats[0], 32'hA0);
        chk("aligned_b3", rd_beats[3], 32'hA3);
        do_read(32'h408, 1'b0);
        chk("cwf_b0", rd_beats[0], 32'hA2);
        chk("cwf_b3", rd_beats[3], 32'hA1);

        // Write-back with a wr_valid gap, read back from the line base.
        d = {32'd4, 32'd3, 32'd2, 32'd1};
        do_write(32'h80C, d, 2);
        do_read(32'h800, 1'b0);
        chk("wb_b0", rd_beats[0], 32'd2);
        chk("wb_b1", rd_beats[1], 32'd3);
        chk("wb_b2", rd_beats[2], 32'd4);
        chk("wb_b3", rd_beats[3], 32'd1);

        // Request held high through a read: next accept right after rsp_last.
        do_read(32'h400, 1'b1);
        chk("hold_idle_ready", req_ready, 1);
        do_read(32'h400, 1'b0);

        // Reset during the second read beat.
        wait_idle();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h400;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < LAT; i++) step();
        chk("rst_mid_b0", rsp_data, mdl[line_word(32'h400, 0)]);
        step();
        rst = 1'b1;
        step();
        chk("rst_mid_valid", rsp_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", req_ready, 0);
        rst = 1'b0;
        step();
        chk("rst_mid_idle", req_ready, 1);
        chk("rst_mid_idle_busy", busy, 0);
        do_read(32'h400, 1'b0);
        chk("rst_mid_keep", rd_beats[1], 32'hA1);

        // Out-of-range address: aliases to word 0, or errors with the feature on.
        d = {32'h14, 32'h13, 32'h12, 32'h11};
        do_write(32'h0, d, -1);
        d = {32'h58, 32'h57, 32'h56, 32'h55};
        do_write(32'h4000, d, -1);
        do_read(32'h0, 1'b0);
`ifdef DMEM_RESP_ERR_EN
        chk("alias_err_word0", rd_beats[0], 32'h11);
`else
        chk("alias_word0", rd_beats[0], 32'h55);
`endif

        // Random mix inside the preloaded region, with occasional high address bits.
        for (int n = 0; n < 40; n++) begin
            a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 255)) << (DL + 2));
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < BL; j++) d[j] = $urandom;
                do_write(a, d, $urandom_range(0, 4) - 1);
            end else begin
                do_read(a, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
